// File: rtl/nal_ep_inserter_if.sv
// Byte stream bundle around the emulation-prevention inserter: FIFO pop side
// (in_dat/in_empty/in_re) and the registered valid/ready output side.
interface nal_ep_inserter_if;
    logic [9:0] in_dat;
    logic       in_empty;
    logic       in_re;
    logic [7:0] out_dat;
    logic       out_vld;
    logic       out_rdy;

    // master: the inserter itself, popping the FIFO and sourcing the output stream
    modport master (
        input  in_dat,
        input  in_empty,
        input  out_rdy,
        output in_re,
        output out_dat,
        output out_vld
    );

    // slave: the surrounding FIFO and downstream consumer
    modport slave (
        output in_dat,
        output in_empty,
        output out_rdy,
        input  in_re,
        input  out_dat,
        input  out_vld
    );
endinterface

// File: rtl/nal_ep_inserter.sv
// Annex-B framer: prefixes each NAL with a start code, inserts 0x03
// emulation-prevention bytes and counts them for rate control.
module nal_ep_inserter #(
    parameter int SC_LEN = 4
) (
    input  logic                clk,
    input  logic                clr_n,
    nal_ep_inserter_if.master   bus,
    output logic [15:0]         ep_cnt
);

    typedef enum logic {PASS, SC} state_t;

    state_t     state, state_nxt;
    logic [1:0] sc_idx, sc_idx_nxt;
    logic [1:0] zcnt, zcnt_nxt;
    logic       sc_done, sc_done_nxt;
    logic       tail_pend, tail_pend_nxt;
    logic [7:0] out_dat_q, out_dat_nxt;
    logic       out_vld_q, out_vld_nxt;
    logic       ep_inc;
    logic       pop;
    logic       load;

    logic [7:0] head_byte;
    logic       head_sof;
    logic       head_eon;

    assign head_byte = bus.in_dat[7:0];
    assign head_sof  = bus.in_dat[9];
    assign head_eon  = bus.in_dat[8];

    assign load        = ~out_vld_q | bus.out_rdy;
    assign bus.out_dat = out_dat_q;
    assign bus.out_vld = out_vld_q;
    assign bus.in_re   = pop & clr_n;

    // Next-state and output selection; everything holds unless the output register can load.
    always_comb begin
        state_nxt     = state;
        sc_idx_nxt    = sc_idx;
        zcnt_nxt      = zcnt;
        sc_done_nxt   = sc_done;
        tail_pend_nxt = tail_pend;
        out_dat_nxt   = out_dat_q;
        out_vld_nxt   = out_vld_q;
        ep_inc        = 1'b0;
        pop           = 1'b0;

        if (load) begin
            case (state)
                PASS: begin
                    if (tail_pend) begin
                        out_dat_nxt   = 8'h03;
                        out_vld_nxt   = 1'b1;
                        tail_pend_nxt = 1'b0;
                        zcnt_nxt      = 2'd0;
                        ep_inc        = 1'b1;
                    end else if (bus.in_empty) begin
                        out_vld_nxt = 1'b0;
                    end else if (head_sof && !sc_done) begin
                        state_nxt   = SC;
                        sc_idx_nxt  = 2'd0;
                        out_vld_nxt = 1'b0;
                    end else if (zcnt == 2'd2 && head_byte <= 8'h03) begin
                        // head byte stays at the FIFO head and is re-evaluated next cycle
                        out_dat_nxt = 8'h03;
                        out_vld_nxt = 1'b1;
                        zcnt_nxt    = 2'd0;
                        ep_inc      = 1'b1;
                    end else begin
                        out_dat_nxt = head_byte;
                        out_vld_nxt = 1'b1;
                        pop         = 1'b1;
                        sc_done_nxt = 1'b0;
                        if (head_byte == 8'h00)
                            zcnt_nxt = (zcnt == 2'd2) ? 2'd2 : zcnt + 2'd1;
                        else
                            zcnt_nxt = 2'd0;
                        if (head_eon) begin
                            zcnt_nxt = 2'd0;
                            if (head_byte == 8'h00)
                                tail_pend_nxt = 1'b1;
                        end
                    end
                end
                SC: begin
                    out_vld_nxt = 1'b1;
                    if (sc_idx != 2'(SC_LEN - 1)) begin
                        out_dat_nxt = 8'h00;
                        sc_idx_nxt  = sc_idx + 2'd1;
                    end else begin
                        out_dat_nxt = 8'h01;
                        sc_idx_nxt  = 2'd0;
                        zcnt_nxt    = 2'd0;
                        sc_done_nxt = 1'b1;
                        state_nxt   = PASS;
                    end
                end
                default: state_nxt = PASS;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= PASS;
            sc_idx    <= 2'd0;
            zcnt      <= 2'd0;
            sc_done   <= 1'b0;
            tail_pend <= 1'b0;
            out_dat_q <= 8'h00;
            out_vld_q <= 1'b0;
            ep_cnt    <= 16'h0000;
        end else begin
            state     <= state_nxt;
            sc_idx    <= sc_idx_nxt;
            zcnt      <= zcnt_nxt;
            sc_done   <= sc_done_nxt;
            tail_pend <= tail_pend_nxt;
            out_dat_q <= out_dat_nxt;
            out_vld_q <= out_vld_nxt;
            if (ep_inc && ep_cnt != 16'hFFFF)
                ep_cnt <= ep_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_nal_ep_inserter.sv
// Self-checking bench for nal_ep_inserter: directed NAL sequences plus a
// randomized stream scored against a byte-level Annex-B framing model.
module tb_nal_ep_inserter;

    localparam int SC_LEN = 4;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [15:0] ep_cnt;

    nal_ep_inserter_if bus ();

    nal_ep_inserter #(.SC_LEN(SC_LEN)) dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .bus    (bus),
        .ep_cnt (ep_cnt)
    );

    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [9:0] src[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         pop_log[$];
    bit         presented   = 1'b0;
    int         m_run       = 0;
    int         m_ep        = 0;
    int         rdy_mode    = 0;
    bit         avail_rand  = 1'b0;
    int         cyc         = 0;
    bit         last_pop    = 1'b0;
    logic [7:0] last_byte   = 8'h00;
    bit         prev_stall  = 1'b0;
    logic [7:0] prev_dat    = 8'h00;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Framing model: start code on sof, 0x03 whenever two payload zeros would be
    // followed by a byte <= 3, and a trailing 0x03 after a NAL ending in 0x00.
    task automatic modelEncode(input logic [9:0] w);
        logic [7:0] b;
        b = w[7:0];
        if (w[9]) begin
            for (int i = 0; i < SC_LEN - 1; i++) exp_q.push_back(8'h00);
            exp_q.push_back(8'h01);
            m_run = 0;
        end
        if (m_run >= 2 && b <= 8'h03) begin
            exp_q.push_back(8'h03);
            m_ep++;
            m_run = 0;
        end
        exp_q.push_back(b);
        m_run = (b == 8'h00) ? m_run + 1 : 0;
        if (w[8]) begin
            if (b == 8'h00) begin
                exp_q.push_back(8'h03);
                m_ep++;
            end
            m_run = 0;
        end
    endtask

    task automatic applyStimulus(input logic [9:0] w);
        src.push_back(w);
    endtask

    // One clock: drive FIFO head and out_rdy at the falling edge, then score the outputs.
    task automatic stepCycle();
        @(negedge clk);
        if (!presented && src.size() > 0 && (!avail_rand || $urandom_range(0, 3) != 0)) begin
            presented = 1'b1;
            modelEncode(src[0]);
        end
        bus.in_empty = !presented;
        bus.in_dat   = presented ? src[0] : 10'($urandom);
        case (rdy_mode)
            0:       bus.out_rdy = 1'b1;
            1:       bus.out_rdy = ($urandom_range(0, 3) != 0);
            default: bus.out_rdy = 1'b0;
        endcase
        #1;
        if (last_pop) begin
            checkOutput("pop_latency_vld", bus.out_vld, 1);
            checkOutput("pop_latency_dat", bus.out_dat, last_byte);
            last_pop = 1'b0;
        end
        if (prev_stall) begin
            checkOutput("stall_vld_hold", bus.out_vld, 1);
            checkOutput("stall_dat_hold", bus.out_dat, prev_dat);
        end
        if (bus.out_vld && bus.out_rdy) begin
            if (exp_q.size() == 0) begin
                checkOutput("extra_byte", bus.out_vld & bus.out_rdy, 0);
            end else begin
                checkOutput($sformatf("out_byte_%0d", vectors), bus.out_dat, exp_q.pop_front());
            end
            got_q.push_back(bus.out_dat);
        end
        prev_stall = bus.out_vld && !bus.out_rdy;
        prev_dat   = bus.out_dat;
        if (prev_stall) checkOutput("stall_in_re", bus.in_re, 0);
        if (bus.in_re) begin
            checkOutput("in_re_when_empty", bus.in_empty, 0);
            if (presented) begin
                last_pop  = 1'b1;
                last_byte = src[0][7:0];
                void'(src.pop_front());
                presented = 1'b0;
            end
            pop_log.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src.size() != 0 || presented) && n < 4000) begin
            stepCycle();
            n++;
        end
        if (n >= 4000) checkOutput({tag, "_timeout"}, exp_q.size(), 0);
        stepCycle();
        checkOutput({tag, "_idle_vld"}, bus.out_vld, 0);
        checkOutput({tag, "_ep_cnt"}, ep_cnt, m_ep);
    endtask

    task automatic checkGot(input string tag, input logic [7:0] want[$]);
        checkOutput({tag, "_len"}, got_q.size(), want.size());
        for (int i = 0; i < want.size() && i < got_q.size(); i++)
            checkOutput($sformatf("%s_b%0d", tag, i), got_q[i], want[i]);
        got_q.delete();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clr_n        = 1'b1;
        bus.in_empty = 1'b1;
        bus.in_dat   = 10'h000;
        bus.out_rdy  = 1'b1;
        #3 clr_n = 1'b0;
        #1;
        checkOutput("rst_in_re", bus.in_re, 0);
        repeat (2) @(negedge clk);
        checkOutput("rst_out_vld", bus.out_vld, 0);
        checkOutput("rst_out_dat", bus.out_dat, 8'h00);
        checkOutput("rst_ep_cnt", ep_cnt, 16'h0000);
        #2 clr_n = 1'b1;

        // 00 00 01 needs one emulation-prevention byte
        applyStimulus(10'h000); applyStimulus(10'h000); applyStimulus(10'h001);
        drain("zero3");
        checkGot("zero3", '{8'h00, 8'h00, 8'h03, 8'h01});
        checkOutput("zero3_ep_const", ep_cnt, 16'd1);

        // sof head: one bubble, four start-code cycles, then pops of 65 and 88
        cyc = 0;
        pop_log.delete();
        applyStimulus(10'h265); applyStimulus(10'h088);
        drain("sof65");
        checkGot("sof65", '{8'h00, 8'h00, 8'h00, 8'h01, 8'h65, 8'h88});
        checkOutput("sof65_pop_count", pop_log.size(), 2);
        if (pop_log.size() >= 2) begin
            checkOutput("sof65_pop0_cycle", pop_log[0], 5);
            checkOutput("sof65_pop1_cycle", pop_log[1], 6);
        end

        applyStimulus(10'h000); applyStimulus(10'h000); applyStimulus(10'h004);
        drain("zz04");
        checkGot("zz04", '{8'h00, 8'h00, 8'h04});

        for (int i = 0; i < 5; i++) applyStimulus(10'h000);
        drain("zero5");
        checkGot("zero5", '{8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h03, 8'h00});
        checkOutput("zero5_ep_const", ep_cnt, 16'd3);

        // NAL ending in 0x00 owes a trailing 0x03; next NAL starts clean
        applyStimulus(10'h011); applyStimulus(10'h100); applyStimulus(10'h342);
        drain("tail");
        checkGot("tail", '{8'h11, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h42});

        // five-cycle stall in the middle of a stream
        applyStimulus(10'h021); applyStimulus(10'h022); applyStimulus(10'h023); applyStimulus(10'h024);
        rdy_mode = 0;
        repeat (2) stepCycle();
        rdy_mode = 2;
        repeat (5) stepCycle();
        rdy_mode = 0;
        drain("stall");
        checkGot("stall", '{8'h21, 8'h22, 8'h23, 8'h24});

        // randomized NALs with FIFO bubbles and random backpressure
        avail_rand = 1'b1;
        rdy_mode   = 1;
        for (int n = 0; n < 40; n++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                logic [7:0] b;
                int r;
                r = $urandom_range(0, 9);
                if (r < 5)      b = 8'h00;
                else if (r < 7) b = 8'($urandom_range(1, 3));
                else            b = 8'($urandom_range(0, 255));
                applyStimulus({(i == 0), (i == len - 1), b});
            end
        end
        drain("random");
        got_q.delete();

        // reset while the second start-code byte is on the output
        avail_rand = 1'b0;
        rdy_mode   = 0;
        applyStimulus(10'h200); applyStimulus(10'h000); applyStimulus(10'h103);
        repeat (3) stepCycle();
        @(negedge clk);
        #1;
        checkOutput("mid_sc_vld", bus.out_vld, 1);
        checkOutput("mid_sc_dat", bus.out_dat, 8'h00);
        clr_n = 1'b0;
        #1;
        checkOutput("mid_sc_rst_vld", bus.out_vld, 0);
        checkOutput("mid_sc_rst_ep", ep_cnt, 16'h0000);
        checkOutput("mid_sc_rst_in_re", bus.in_re, 0);
        exp_q.delete();
        got_q.delete();
        m_run      = 0;
        m_ep       = 0;
        last_pop   = 1'b0;
        prev_stall = 1'b0;
        if (presented) modelEncode(src[0]);
        @(negedge clk);
        #2 clr_n = 1'b1;
        drain("rst_resume");
        checkGot("rst_resume", '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03, 8'h03});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nal_ep_inserter.md
# nal_ep_inserter

Downstream consumer of the 1-deep byte FIFO on the H.264 bitstream output path. It pops RBSP bytes tagged with NAL-start and NAL-end flags, prefixes each NAL with an Annex-B start code, inserts emulation-prevention bytes (0x03), and drives a registered valid/ready byte stream toward the output interface. It also counts inserted 0x03 bytes for rate-control bookkeeping.

## Interface
- SC_LEN, 4: start-code length in bytes; legal values 3 (00 00 01) or 4 (00 00 00 01).
- clk  in  1  clock.
- clr_n  in  1  reset, asynchronous, active-low.
- in_dat  in  10  FIFO head word, valid when in_empty=0: [9] sof (first byte of NAL), [8] eon (last byte of NAL), [7:0] RBSP byte. The upstream FIFO is instantiated with dw=10.
- in_empty  in  1  FIFO empty.
- in_re  out  1  FIFO pop, combinational; the head word is consumed on the clk edge where in_re=1.
- out_dat  out  8  output byte, registered.
- out_vld  out  1  output byte valid, registered.
- out_rdy  in  1  downstream accepts out_dat on an edge where out_vld & out_rdy.
- ep_cnt  out  16  number of inserted 0x03 bytes since reset; saturates at 0xFFFF.

## Operation
- load = ~out_vld | out_rdy. The output register and all state advance only when load=1.
- Internal state:
  - FSM {PASS, SC}.
  - sc_idx, 0..SC_LEN-1.
  - zcnt, 0..2: count of consecutive 0x00 bytes emitted, saturating.
  - sc_done: the start code for the current head sof byte has been emitted.
  - tail_pend: a trailing 0x03 is owed.
- Priority in PASS when load=1:
  1. tail_pend=1: emit 0x03; clear tail_pend; zcnt=0; ep_cnt+1; no pop.
  2. in_empty=1: out_vld<=0; no pop.
  3. in_dat[9]=1 and sc_done=0: go to SC with sc_idx=0; out_vld<=0; no pop.
  4. zcnt=2 and in_dat[7:0]<=0x03: emit 0x03; zcnt=0; ep_cnt+1; no pop. The same head byte is re-evaluated next cycle.
  5. Otherwise: emit in_dat[7:0] and pop (in_re=1).
     - zcnt: 0x00 → min(zcnt+1,2); any other byte → 0.
     - sc_done <= 0.
     - If in_dat[8]=1 and byte==0x00: tail_pend<=1.
     - If in_dat[8]=1: zcnt<=0 after the tail, so there is no carry across NALs.
- SC state when load=1:
  - sc_idx<SC_LEN-1: emit 0x00 and increment sc_idx.
  - sc_idx=SC_LEN-1: emit 0x01; zcnt=0; sc_done=1; return to PASS.
  - Start-code zeros never count toward zcnt and never trigger insertion.
- When load=0: out_dat and out_vld hold, in_re=0, and no state changes.
- in_re = clr_n & load & (state==PASS) & ~tail_pend & ~in_empty & ~(in_dat[9] & ~sc_done) & ~(zcnt==2 & in_dat[7:0]<=3).
- A sof=1 and eon=1 single-byte NAL is legal: start code, then the byte, then 0x03 if the byte is 0x00.

## Timing
- Reset values (asynchronous, on clr_n low):
  - out_vld=0, out_dat=0x00, ep_cnt=0.
  - state=PASS, sc_idx=0, zcnt=0, sc_done=0, tail_pend=0.
  - in_re is forced 0 while clr_n=0.
- Latency:
  - A byte popped on edge n appears on out_dat after edge n, i.e. it is valid during cycle n+1.
  - A sof head costs 1 bubble cycle (SC entry), then SC_LEN start-code cycles, before the byte is emitted.
- Throughput: 1 byte/cycle with out_rdy held high, except for SC entry bubbles and inserted 0x03 bytes.
- Backpressure: while out_vld=1 and out_rdy=0, out_dat is stable and in_re=0.
- Reset mid-start-code or mid-tail: all state is cleared. The NAL resumes as if fresh, and a head sof byte re-triggers a full start code.
- ep_cnt increments on the edge that loads a 0x03 into the output register and holds at 0xFFFF.

## Test plan
- Bytes 00,00,01 (no sof/eon), out_rdy=1 → out 00,00,03,01; ep_cnt=1.
- SC_LEN=4, single word sof=1 byte 0x65, then 0x88 → out 00,00,00,01,65,88; in_re high only on the cycles 65 and 88 are popped.
- Bytes 00,00,00,00,00 → out 00,00,03,00,00,03,00; ep_cnt=2. Bytes 00,00,04 → out 00,00,04; no insertion.
- eon=1 on byte 0x00 following 0x11 → out 11,00,03. The next NAL's sof with SC_LEN=3 yields 00,00,01 with no extra 0x03.
- Hold out_rdy=0 for 5 cycles mid-stream → out_dat/out_vld stable, in_re=0; no byte is lost or duplicated after release.
- Assert clr_n=0 during the start code's 2nd byte → out_vld=0 and ep_cnt=0 immediately. After release, a full start code is re-emitted before the sof byte.
